// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART transmitter among NUM_REQ byte producers.
// Each requester has a FIFO of {last, data}; grants change only at packet ends.
// Ports: clk, reset (sync, active-high); req_valid/req_data/req_last in,
// req_ready out (FIFO not full); tx_load/tx_data out, tx_busy in (UART core);
// grant_id/grant_active out (arbiter status); ovf out (sticky write-while-full).
// Option: define UART_TX_SCHED_PRIO_EN for fixed priority (req 0 highest)
// instead of round-robin arbitration.
module uart_tx_sched #(
   parameter int NUM_REQ      = 2,
   parameter int FIFO_LOG2    = 2,
   parameter int BUSY_TIMEOUT = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 tx_load,
   output logic [7:0]           tx_data,
   input  logic                 tx_busy,
   output logic [1:0]           grant_id,
   output logic                 grant_active,
   output logic [NUM_REQ-1:0]   ovf
);

   localparam int DEPTH = 2 ** FIFO_LOG2;
   localparam int PW    = FIFO_LOG2 + 1;
   localparam int CW    = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ARB       = 3'd1,
      LOAD      = 3'd2,
      WAIT_BUSY = 3'd3,
      WAIT_DONE = 3'd4,
      HOLD      = 3'd5
   } state_t;

   state_t state, state_nx;

   logic [8:0]         mem [NUM_REQ][DEPTH];
   logic [PW-1:0]      wr_ptr [NUM_REQ];
   logic [PW-1:0]      rd_ptr [NUM_REQ];
   logic [NUM_REQ-1:0] empty, full, wr_en;
   logic [1:0]         pick, sel;
   logic [8:0]         head;
   logic               grant_ne;
   logic               fire, grab, rel;
   logic               last_q;
   logic [CW-1:0]      cnt;

   always_comb begin
      empty = '0;
      full  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         empty[i] = (wr_ptr[i] == rd_ptr[i]);
         full[i]  = (wr_ptr[i][PW-1] != rd_ptr[i][PW-1]) &&
                    (wr_ptr[i][PW-2:0] == rd_ptr[i][PW-2:0]);
      end
   end

   assign req_ready = ~full;
   assign wr_en     = req_valid & ~full;

`ifdef UART_TX_SCHED_PRIO_EN
   always_comb begin
      pick = grant_id;
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (!empty[i]) pick = 2'(i);
   end
`else
   // Search starts just past the last grant; the last grant is tried last.
   always_comb begin
      logic found;
      int   idx;
      pick  = grant_id;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(grant_id) + k) % NUM_REQ;
         if (!found && !empty[idx]) begin
            pick  = 2'(idx);
            found = 1'b1;
         end
      end
   end
`endif

   // In ARB the pop target is the requester being granted this cycle.
   assign sel = (state == ARB) ? pick : grant_id;

   always_comb begin
      head     = '0;
      grant_ne = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel == 2'(i))
            head = mem[i][rd_ptr[i][FIFO_LOG2-1:0]];
         if (grant_id == 2'(i))
            grant_ne = !empty[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // fire marks the edge that loads a byte; the cycle after is LOAD,
   // the single cycle in which tx_load is high.
   always_comb begin
      state_nx = state;
      fire     = 1'b0;
      grab     = 1'b0;
      rel      = 1'b0;
      unique case (state)
         IDLE: begin
            if (!(&empty) || (|wr_en)) state_nx = ARB;
         end
         ARB: begin
            if (&empty) begin
               state_nx = IDLE;
            end else begin
               grab = 1'b1;
               if (!tx_busy) begin
                  fire     = 1'b1;
                  state_nx = LOAD;
               end else begin
                  state_nx = HOLD;
               end
            end
         end
         LOAD: state_nx = WAIT_BUSY;
         WAIT_BUSY: begin
            if (tx_busy || cnt == CW'(BUSY_TIMEOUT - 1))
               state_nx = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               if (last_q) begin
                  rel      = 1'b1;
                  state_nx = (&empty) ? IDLE : ARB;
               end else if (grant_ne) begin
                  fire     = 1'b1;
                  state_nx = LOAD;
               end else begin
                  state_nx = HOLD;
               end
            end
         end
         HOLD: begin
            if (grant_ne && !tx_busy) begin
               fire     = 1'b1;
               state_nx = LOAD;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_load      <= 1'b0;
         tx_data      <= '0;
         grant_id     <= 2'(NUM_REQ - 1);
         grant_active <= 1'b0;
         last_q       <= 1'b0;
         cnt          <= '0;
      end else begin
         tx_load <= fire;
         if (fire) begin
            tx_data <= head[7:0];
            last_q  <= head[8];
         end
         if (grab) begin
            grant_id     <= pick;
            grant_active <= 1'b1;
         end
         if (rel) grant_active <= 1'b0;
         if (state == WAIT_BUSY) cnt <= cnt + 1'b1;
         else                    cnt <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
            if (req_valid[i] && full[i]) ovf[i] <= 1'b1;
            if (fire && sel == 2'(i)) rd_ptr[i] <= rd_ptr[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++)
         if (wr_en[i])
            mem[i][wr_ptr[i][FIFO_LOG2-1:0]] <= {req_last[i], req_data[8*i +: 8]};
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: scoreboard bench for uart_tx_sched with a UART busy model.
// Busy model modes: 0 = 10-cycle busy per load, 1 = stuck high, 2 = never high.
module tb_uart_tx_sched;
   localparam int N = 2;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0]   req_last = '0;
   logic [N-1:0]   req_ready;
   logic           tx_load;
   logic [7:0]     tx_data;
   logic           tx_busy = 1'b0;
   logic [1:0]     grant_id;
   logic           grant_active;
   logic [N-1:0]   ovf;

   uart_tx_sched #(.NUM_REQ(N), .FIFO_LOG2(2), .BUSY_TIMEOUT(3)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready),
      .tx_load(tx_load), .tx_data(tx_data), .tx_busy(tx_busy),
      .grant_id(grant_id), .grant_active(grant_active), .ovf(ovf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;
   int mode  = 0;
   int bcnt  = 0;

   always @(posedge clk) begin
      if (mode == 1) tx_busy <= 1'b1;
      else if (mode == 2) tx_busy <= 1'b0;
      else if (tx_load) begin
         tx_busy <= 1'b1;
         bcnt    <= 10;
      end else if (bcnt > 1) bcnt <= bcnt - 1;
      else begin
         bcnt    <= 0;
         tx_busy <= 1'b0;
      end
   end

   logic [7:0] got_q[$];
   int         got_t[$];
   logic [7:0] exp_q[$];

   always begin
      @(posedge clk);
      #1;
      if (tx_load) begin
         got_q.push_back(tx_data);
         got_t.push_back(cyc);
         total++;
         if (tx_busy !== 1'b0) begin
            bad++;
            $display("FAIL load_while_busy got=%0b want=0", tx_busy);
         end
      end
   end

   task automatic cyc_wr(input logic [N-1:0] v, input logic [8*N-1:0] d,
                         input logic [N-1:0] l);
      req_valid = v;
      req_data  = d;
      req_last  = l;
      @(negedge clk);
      req_valid = '0;
      req_last  = '0;
   endtask

   task automatic wait_out(input int n, input int budget);
      for (int k = 0; k < budget && got_q.size() < n; k++) @(negedge clk);
   endtask

   task automatic do_reset(input int m);
      mode = 0;
      req_valid = '0;
      repeat (25) @(negedge clk);
      mode  = m;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      got_q.delete();
      got_t.delete();
      exp_q.delete();
      @(negedge clk);
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      total++; if (tx_load !== 1'b0) begin bad++; $display("FAIL rst_load got=%0h want=0", tx_load); end
      total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%0h want=0", tx_data); end
      total++; if (req_ready !== 2'b11) begin bad++; $display("FAIL rst_ready got=%0b want=11", req_ready); end
      total++; if (grant_active !== 1'b0) begin bad++; $display("FAIL rst_gact got=%0b want=0", grant_active); end
      total++; if (grant_id !== 2'd1) begin bad++; $display("FAIL rst_gid got=%0d want=1", grant_id); end
      total++; if (ovf !== 2'b00) begin bad++; $display("FAIL rst_ovf got=%0b want=0", ovf); end
   endtask

   task automatic test_single;
      int t0;
      do_reset(0);
      t0 = cyc;
      exp_q.push_back(8'h41);
      cyc_wr(2'b01, {8'h00, 8'h41}, 2'b01);
      wait_out(1, 40);
      total++;
      if (got_q.size() != 1) begin
         bad++; $display("FAIL single_cnt got=%0d want=1", got_q.size());
      end else begin
         total++; if (got_q[0] !== exp_q[0]) begin bad++; $display("FAIL single_data got=%0h want=%0h", got_q[0], exp_q[0]); end
         total++; if (got_t[0] != t0 + 2) begin bad++; $display("FAIL single_lat got=%0d want=%0d", got_t[0] - t0, 2); end
      end
      while (cyc < t0 + 12) @(negedge clk);
      total++; if (grant_active !== 1'b1) begin bad++; $display("FAIL single_gact_busy got=%0b want=1", grant_active); end
      while (cyc < t0 + 14) @(negedge clk);
      total++; if (grant_active !== 1'b0) begin bad++; $display("FAIL single_gact_done got=%0b want=0", grant_active); end
      total++; if (dut.state !== 3'd0) begin bad++; $display("FAIL single_idle got=%0d want=0", dut.state); end
   endtask

   task automatic test_rr;
      logic [7:0] e;
      do_reset(0);
`ifdef UART_TX_SCHED_PRIO_EN
      exp_q = '{8'h01, 8'h02, 8'h01, 8'h02, 8'h11, 8'h11};
`else
      exp_q = '{8'h01, 8'h02, 8'h11, 8'h01, 8'h02, 8'h11};
`endif
      cyc_wr(2'b11, {8'h11, 8'h01}, 2'b10);
      cyc_wr(2'b01, {8'h00, 8'h02}, 2'b01);
      cyc_wr(2'b11, {8'h11, 8'h01}, 2'b10);
      cyc_wr(2'b01, {8'h00, 8'h02}, 2'b01);
      wait_out(6, 300);
      total++;
      if (got_q.size() != 6) begin
         bad++; $display("FAIL rr_cnt got=%0d want=6", got_q.size());
      end else begin
         total++; if (got_t[1] - got_t[0] != 12) begin bad++; $display("FAIL rr_b2b_gap got=%0d want=12", got_t[1] - got_t[0]); end
         for (int k = 0; k < 6; k++) begin
            e = exp_q.pop_front();
            total++; if (got_q[k] !== e) begin bad++; $display("FAIL rr_order[%0d] got=%0h want=%0h", k, got_q[k], e); end
         end
      end
   endtask

   task automatic test_hold;
      logic [7:0] e;
      do_reset(0);
      exp_q = '{8'h01, 8'h02, 8'h11};
      cyc_wr(2'b11, {8'h11, 8'h01}, 2'b10);
      repeat (40) @(negedge clk);
      total++; if (dut.state !== 3'd5) begin bad++; $display("FAIL hold_state got=%0d want=5", dut.state); end
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL hold_gid got=%0d want=0", grant_id); end
      total++; if (got_q.size() != 1) begin bad++; $display("FAIL hold_gap_cnt got=%0d want=1", got_q.size()); end
      repeat (10) @(negedge clk);
      cyc_wr(2'b01, {8'h00, 8'h02}, 2'b01);
      wait_out(3, 100);
      total++;
      if (got_q.size() != 3) begin
         bad++; $display("FAIL hold_cnt got=%0d want=3", got_q.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            total++; if (got_q[k] !== e) begin bad++; $display("FAIL hold_order[%0d] got=%0h want=%0h", k, got_q[k], e); end
         end
      end
   endtask

   task automatic test_timeout;
      int t0;
      do_reset(2);
      t0 = cyc;
      exp_q = '{8'h51, 8'h52};
      cyc_wr(2'b01, {8'h00, 8'h51}, 2'b00);
      cyc_wr(2'b01, {8'h00, 8'h52}, 2'b01);
      wait_out(2, 60);
      total++;
      if (got_q.size() != 2) begin
         bad++; $display("FAIL tmo_cnt got=%0d want=2", got_q.size());
      end else begin
         total++; if (got_t[0] != t0 + 2) begin bad++; $display("FAIL tmo_first got=%0d want=2", got_t[0] - t0); end
         total++; if (got_t[1] - got_t[0] != 5) begin bad++; $display("FAIL tmo_gap got=%0d want=5", got_t[1] - got_t[0]); end
         total++; if (got_q[1] !== exp_q[1]) begin bad++; $display("FAIL tmo_data got=%0h want=%0h", got_q[1], exp_q[1]); end
      end
   endtask

   task automatic test_reset_mid;
      int k;
      do_reset(0);
      exp_q.push_back(8'hA1);
      cyc_wr(2'b01, {8'h00, 8'hA1}, 2'b00);
      cyc_wr(2'b01, {8'h00, 8'hA2}, 2'b00);
      cyc_wr(2'b01, {8'h00, 8'hA3}, 2'b01);
      k = 0;
      while (dut.state !== 3'd4 && k < 40) begin
         @(negedge clk);
         k++;
      end
      total++; if (k >= 40) begin bad++; $display("FAIL rmid_reach got=%0d want=4", dut.state); end
      reset = 1'b1;
      @(negedge clk);
      total++; if (dut.state !== 3'd0) begin bad++; $display("FAIL rmid_state got=%0d want=0", dut.state); end
      total++; if (tx_load !== 1'b0) begin bad++; $display("FAIL rmid_load got=%0b want=0", tx_load); end
      total++; if (ovf !== 2'b00) begin bad++; $display("FAIL rmid_ovf got=%0b want=0", ovf); end
      total++; if (grant_id !== 2'd1) begin bad++; $display("FAIL rmid_gid got=%0d want=1", grant_id); end
      total++; if (grant_active !== 1'b0) begin bad++; $display("FAIL rmid_gact got=%0b want=0", grant_active); end
      reset = 1'b0;
      repeat (40) @(negedge clk);
      total++; if (got_q.size() != 1) begin bad++; $display("FAIL rmid_flushed got=%0d want=1", got_q.size()); end
      else begin
         total++; if (got_q[0] !== exp_q[0]) begin bad++; $display("FAIL rmid_data got=%0h want=%0h", got_q[0], exp_q[0]); end
      end
   endtask

   task automatic test_overflow;
      do_reset(1);
      cyc_wr(2'b01, {8'h00, 8'hC1}, 2'b00);
      cyc_wr(2'b01, {8'h00, 8'hC2}, 2'b00);
      cyc_wr(2'b01, {8'h00, 8'hC3}, 2'b00);
      total++; if (req_ready[0] !== 1'b1) begin bad++; $display("FAIL ovf_ready3 got=%0b want=1", req_ready[0]); end
      cyc_wr(2'b01, {8'h00, 8'hC4}, 2'b00);
      total++; if (req_ready[0] !== 1'b0) begin bad++; $display("FAIL ovf_ready4 got=%0b want=0", req_ready[0]); end
      total++; if (ovf !== 2'b00) begin bad++; $display("FAIL ovf_early got=%0b want=0", ovf); end
      cyc_wr(2'b01, {8'h00, 8'hC5}, 2'b01);
      total++; if (ovf !== 2'b01) begin bad++; $display("FAIL ovf_set got=%0b want=01", ovf); end
      total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL ovf_ready5 got=%0b want=10", req_ready); end
      repeat (20) @(negedge clk);
      total++; if (got_q.size() != 0) begin bad++; $display("FAIL ovf_noload got=%0d want=0", got_q.size()); end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_rr();
      test_hold();
      test_timeout();
      test_reset_mid();
      test_overflow();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
